rr_mux_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the 4-to-1 multiplexer among four requesters.
- Each requester owns one mux input (a, b, c, d). The block grants the mux to one requester at a time and drives the select.
- It registers the selected data and bounds each owner's tenure with a hold counter.
- It sits between the requesting channels and the shared mux datapath.

---
 rtl/rr_mux_arbiter.sv | 108 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that time-shares one 4:1 mux among four requesters.
// Tenure is capped at MAX_HOLD cycles only while another requester is waiting.
module rr_mux_arbiter #(
    parameter int W        = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [3:0]   grant,
    output logic [1:0]   sel,
    output logic         busy,
    output logic [W-1:0] dout,
    output logic         dout_valid
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0]   state;
    logic [1:0]   last;
    logic [7:0]   hold_cnt;
    logic [3:0]   others;
    logic [1:0]   win_idle;
    logic [1:0]   win_own;
    logic [W-1:0] mux_d;

    // First set bit at or after start, wrapping 3->0; lowest offset wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        others   = req & ~(4'b0001 << sel);
        win_idle = pick(req, last + 2'd1);
        win_own  = pick(req, sel + 2'd1);
        case (sel)
            2'd0:    mux_d = a;
            2'd1:    mux_d = b;
            2'd2:    mux_d = c;
            default: mux_d = d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            grant      <= 4'b0000;
            sel        <= 2'b00;
            busy       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            last       <= 2'd3;
            hold_cnt   <= 8'd0;
        end else begin
            dout       <= busy ? mux_d : '0;
            dout_valid <= busy;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state    <= S_GRANT;
                        sel      <= win_idle;
                        grant    <= 4'b0001 << win_idle;
                        busy     <= 1'b1;
                        hold_cnt <= 8'd0;
                    end
                end
                S_GRANT: begin
                    if (!req[sel]) begin
                        last     <= sel;
                        hold_cnt <= 8'd0;
                        if (|others) begin
                            sel   <= win_own;
                            grant <= 4'b0001 << win_own;
                        end else begin
                            state <= S_IDLE;
                            grant <= 4'b0000;
                            busy  <= 1'b0;
                        end
                    end else if (|others && hold_cnt >= HOLD_LAST) begin
                        last     <= sel;
                        sel      <= win_own;
                        grant    <= 4'b0001 << win_own;
                        hold_cnt <= 8'd0;
                    end else if (!(|others)) begin
                        // Sole requester: keep the grant, park the counter so a
                        // newcomer triggers rotation on its first cycle.
                        if (hold_cnt < HOLD_LAST) hold_cnt <= hold_cnt + 8'd1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: reset, fairness, handoff, hold, idle release, mid-tenure reset.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] a, b, c, d;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic [7:0] dout;
    logic       dout_valid;

    int n_chk  = 0;
    int n_fail = 0;

    rr_mux_arbiter #(.W(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .grant(grant), .sel(sel), .busy(busy),
        .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    logic [7:0] data_of [4];

    initial begin
        a = 8'hA1; b = 8'hB2; c = 8'hC3; d = 8'hD4;
        data_of[0] = 8'hA1; data_of[1] = 8'hB2; data_of[2] = 8'hC3; data_of[3] = 8'hD4;
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_dv", 32'(dout_valid), 32'h0);

        // Fairness: req=1111 from reset gives 4-cycle tenures 0,1,2,3,0
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        chk("first_sel", 32'(sel), 32'h0);
        chk("first_busy", 32'(busy), 32'h1);
        chk("first_dv", 32'(dout_valid), 32'h0);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("rr_grant_%0d", i), 32'(grant), 32'(4'b0001 << ((i / 4) % 4)));
            if (i >= 1) begin
                chk($sformatf("rr_dv_%0d", i), 32'(dout_valid), 32'h1);
                chk($sformatf("rr_dout_%0d", i), 32'(dout), 32'(data_of[((i - 1) / 4) % 4]));
            end
            step();
        end

        // Direct handoff from owner 2: index 3 wins before 0
        do_reset();
        req = 4'b0100;
        step();
        chk("ho_grant2", 32'(grant), 32'h4);
        req = 4'b1001;
        step();
        chk("ho_grant3", 32'(grant), 32'h8);
        chk("ho_busy", 32'(busy), 32'h1);
        chk("ho_dout_c", 32'(dout), 32'hC3);
        step();
        chk("ho_dout_d", 32'(dout), 32'hD4);
        chk("ho_dv", 32'(dout_valid), 32'h1);

        // Uncontended hold then newcomer rotates immediately
        do_reset();
        req = 4'b0010;
        step();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("hold_%0d", i), 32'(grant), 32'h2);
            step();
        end
        req = 4'b1010;
        step();
        chk("hold_rot", 32'(grant), 32'h8);

        // Release to idle, then last=0 favours index 1
        do_reset();
        req = 4'b0001;
        step();
        chk("rel_grant", 32'(grant), 32'h1);
        req = 4'b0000;
        step();
        chk("rel_idle_grant", 32'(grant), 32'h0);
        chk("rel_idle_busy", 32'(busy), 32'h0);
        chk("rel_last_dv", 32'(dout_valid), 32'h1);
        chk("rel_last_dout", 32'(dout), 32'hA1);
        step();
        chk("rel_dv0", 32'(dout_valid), 32'h0);
        chk("rel_dout0", 32'(dout), 32'h0);
        req = 4'b0011;
        step();
        chk("rel_next", 32'(grant), 32'h2);

        // Reset during owner 3's tenure
        do_reset();
        req = 4'b1000;
        step();
        step();
        chk("mr_pre_dout", 32'(dout), 32'hD4);
        rst_n = 1'b0;
        step();
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_sel", 32'(sel), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_dout", 32'(dout), 32'h0);
        chk("mr_dv", 32'(dout_valid), 32'h0);
        rst_n = 1'b1;
        req   = 4'b1001;
        step();
        chk("mr_after", 32'(grant), 32'h1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
